// File: rtl/comparator_bist.sv
// Exhaustive self-test sweep for an external WIDTH-bit magnitude comparator.
// Optional first-failure capture ports are enabled by defining COMPARATOR_BIST_FAIL_CAPTURE_EN.
module comparator_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    input  logic [2:0]         CM,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_cnt,
`ifdef COMPARATOR_BIST_FAIL_CAPTURE_EN
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [2:0]         fail_cm,
    output logic               fail_valid,
`endif
    output logic [1:0]         fsm_state
);

    localparam int VW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    state_t        state;
    logic [VW-1:0] vec;
    logic [3:0]    settle_cnt;
    logic [2:0]    exp_cm;
    logic          mismatch;
    logic [EW-1:0] err_next;

    assign A         = vec[VW-1:WIDTH];
    assign B         = vec[WIDTH-1:0];
    assign fsm_state = state;

    // Expected answer is one-hot, so any non-one-hot CM is automatically a mismatch.
    always_comb begin
        exp_cm   = {A > B, A == B, A < B};
        mismatch = (CM != exp_cm);
        err_next = err_cnt;
        if (mismatch && !(&err_cnt)) begin
            err_next = err_cnt + EW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
`ifdef COMPARATOR_BIST_FAIL_CAPTURE_EN
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cm    <= '0;
            fail_valid <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= WAIT;
                        vec        <= '0;
                        err_cnt    <= '0;
                        settle_cnt <= SETTLE_L;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
`ifdef COMPARATOR_BIST_FAIL_CAPTURE_EN
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_cm    <= '0;
                        fail_valid <= 1'b0;
`endif
                    end
                end
                WAIT: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    err_cnt <= err_next;
`ifdef COMPARATOR_BIST_FAIL_CAPTURE_EN
                    if (mismatch && !fail_valid) begin
                        fail_a     <= A;
                        fail_b     <= B;
                        fail_cm    <= CM;
                        fail_valid <= 1'b1;
                    end
`endif
                    // The last vector ends the sweep instead of wrapping back to zero.
                    if (&vec) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state      <= WAIT;
                        vec        <= vec + VW'(1);
                        settle_cnt <= SETTLE_L;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
